// File: rtl/pcs_pkg.sv
// Shared definitions for the RX PCS block-lock logic: sync header codes,
// per-lane lock FSM states and the header classification helper.
package pcs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [1:0] {
    RESET_CNT,
    TEST_SH,
    SLIP_WAIT
  } lock_state_t;

  // A sync header is usable only if its two bits differ (data or control block).
  function automatic logic sh_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/block_lock_lane.sv
// One lane of the 64b/66b block-lock controller: header window counters,
// lock FSM, gearbox slip pulse and a saturating slip counter.
module block_lock_lane
  import pcs_pkg::*;
#(
  parameter int HEADER_WIDTH     = 2,
  parameter int SH_CNT_MAX       = 64,
  parameter int SH_INVALID_MAX   = 16,
  parameter int SLIP_WAIT_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    hdr_valid,
  input  logic [HEADER_WIDTH-1:0] rx_hdr,
  output logic                    slip,
  output logic                    block_lock,
  output logic [7:0]              slip_count
);

  localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INVALID_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT_CYCLES - 1);

  lock_state_t       state;
  lock_state_t       state_nxt;
  logic [CNT_W-1:0]  sh_cnt;
  logic [INV_W-1:0]  sh_inv;
  logic [WAIT_W-1:0] wait_cnt;

  logic              take_hdr;
  logic              hdr_bad;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [INV_W-1:0]  inv_nxt;
  logic              slip_evt;
  logic              win_done;
  logic              lock_nxt;
  logic              slip_nxt;
  logic [7:0]        slip_cnt_nxt;

  // Classify the incoming header and work out the counts including it; a
  // header arriving in RESET_CNT is counted against a freshly cleared window.
  always_comb begin
    take_hdr = enable && hdr_valid && (state != SLIP_WAIT);
    hdr_bad  = !sh_valid(rx_hdr);
    cnt_nxt  = (state == TEST_SH) ? sh_cnt : '0;
    inv_nxt  = (state == TEST_SH) ? sh_inv : '0;
    if (take_hdr) begin
      cnt_nxt = cnt_nxt + CNT_W'(1);
      if (hdr_bad) begin
        inv_nxt = inv_nxt + INV_W'(1);
      end
    end
    // Slip takes priority over window completion on the same header.
    slip_evt = take_hdr && (block_lock ? (inv_nxt == INV_LAST) : hdr_bad);
    win_done = take_hdr && !slip_evt && (cnt_nxt == CNT_LAST);
  end

  // Lock FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_CNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Lock FSM next-state decode; a low enable parks the lane in RESET_CNT.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = RESET_CNT;
    end else begin
      case (state)
        RESET_CNT, TEST_SH: begin
          if (slip_evt) begin
            state_nxt = SLIP_WAIT;
          end else if (win_done) begin
            state_nxt = RESET_CNT;
          end else begin
            state_nxt = TEST_SH;
          end
        end
        SLIP_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state_nxt = RESET_CNT;
          end
        end
        default: state_nxt = RESET_CNT;
      endcase
    end
  end

  // Next values of the registered lane outputs.
  always_comb begin
    lock_nxt     = block_lock;
    slip_nxt     = 1'b0;
    slip_cnt_nxt = slip_count;
    if (!enable || slip_evt) begin
      lock_nxt = 1'b0;
    end else if (win_done) begin
      lock_nxt = 1'b1;
    end
    if (slip_evt) begin
      slip_nxt = 1'b1;
      if (slip_count != 8'hFF) begin
        slip_cnt_nxt = slip_count + 8'd1;
      end
    end
  end

  // Window counters, settle timer and output registers; slip_count survives
  // enable drops and is cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_cnt     <= '0;
      sh_inv     <= '0;
      wait_cnt   <= '0;
      block_lock <= 1'b0;
      slip       <= 1'b0;
      slip_count <= 8'd0;
    end else begin
      sh_cnt     <= enable ? cnt_nxt : '0;
      sh_inv     <= enable ? inv_nxt : '0;
      wait_cnt   <= (enable && (state == SLIP_WAIT)) ? wait_cnt + WAIT_W'(1) : '0;
      block_lock <= lock_nxt;
      slip       <= slip_nxt;
      slip_count <= slip_cnt_nxt;
    end
  end

endmodule

// File: rtl/rx_block_lock_ctrl.sv
// Multi-lane 64b/66b RX block-lock controller. Each lane runs its own lock
// FSM; the lanes only meet in the registered aggregate ALL_LOCKED.
module rx_block_lock_ctrl #(
  parameter int LANES          = 2,
  parameter int HEADER_WIDTH   = 2,
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int SLIP_WAIT      = 32
) (
  input  logic                            RX_CLK,
  input  logic                            RST,
  input  logic                            ENABLE,
  input  logic [LANES-1:0]                HDR_VALID,
  input  logic [LANES*HEADER_WIDTH-1:0]   RX_HDR,
  output logic [LANES-1:0]                SLIP,
  output logic [LANES-1:0]                BLOCK_LOCK,
  output logic                            ALL_LOCKED,
  output logic [LANES*8-1:0]              SLIP_COUNT
);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    block_lock_lane #(
      .HEADER_WIDTH     (HEADER_WIDTH),
      .SH_CNT_MAX       (SH_CNT_MAX),
      .SH_INVALID_MAX   (SH_INVALID_MAX),
      .SLIP_WAIT_CYCLES (SLIP_WAIT)
    ) u_lane (
      .clk        (RX_CLK),
      .rst        (RST),
      .enable     (ENABLE),
      .hdr_valid  (HDR_VALID[g]),
      .rx_hdr     (RX_HDR[g*HEADER_WIDTH +: HEADER_WIDTH]),
      .slip       (SLIP[g]),
      .block_lock (BLOCK_LOCK[g]),
      .slip_count (SLIP_COUNT[g*8 +: 8])
    );
  end

  // Aggregate lock, one cycle behind the per-lane lock flags.
  always_ff @(posedge RX_CLK or posedge RST) begin
    if (RST) begin
      ALL_LOCKED <= 1'b0;
    end else begin
      ALL_LOCKED <= &BLOCK_LOCK;
    end
  end

endmodule

// File: tb/tb_rx_block_lock_ctrl.sv
// Bench for rx_block_lock_ctrl: directed scenarios plus randomized traffic,
// all compared every cycle against a behavioural lane model.
module tb_rx_block_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  hv;
  logic [3:0]  hdr;
  logic [1:0]  SLIP;
  logic [1:0]  BLOCK_LOCK;
  logic        ALL_LOCKED;
  logic [15:0] SLIP_COUNT;

  always #5 clk = ~clk;

  rx_block_lock_ctrl dut (
    .RX_CLK     (clk),
    .RST        (rst),
    .ENABLE     (en),
    .HDR_VALID  (hv),
    .RX_HDR     (hdr),
    .SLIP       (SLIP),
    .BLOCK_LOCK (BLOCK_LOCK),
    .ALL_LOCKED (ALL_LOCKED),
    .SLIP_COUNT (SLIP_COUNT)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: per lane, headers seen in the window, invalid headers
  // in the window, remaining ignore cycles, lock flag, slip pulse, slip total.
  int m_cnt[2];
  int m_bad[2];
  int m_wait[2];
  int m_sc[2];
  bit m_lock[2];
  bit m_slip[2];
  bit m_all;
  bit badpos[64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      m_cnt[l] = 0; m_bad[l] = 0; m_wait[l] = 0; m_sc[l] = 0;
      m_lock[l] = 0; m_slip[l] = 0;
    end
    m_all = 0;
  endtask

  task automatic model_step();
    m_all = m_lock[0] && m_lock[1];
    for (int l = 0; l < 2; l++) begin
      logic [1:0] h;
      bit bad;
      h = hdr[2*l +: 2];
      bad = (h == 2'b00) || (h == 2'b11);
      m_slip[l] = 0;
      if (!en) begin
        m_lock[l] = 0; m_cnt[l] = 0; m_bad[l] = 0; m_wait[l] = 0;
      end else if (m_wait[l] > 0) begin
        m_wait[l]--;
      end else if (hv[l]) begin
        m_cnt[l]++;
        if (bad) m_bad[l]++;
        if (m_lock[l] ? (m_bad[l] == 16) : bad) begin
          m_slip[l] = 1;
          m_lock[l] = 0;
          if (m_sc[l] < 255) m_sc[l]++;
          m_wait[l] = 32;
          m_cnt[l] = 0;
          m_bad[l] = 0;
        end else if (m_cnt[l] == 64) begin
          m_lock[l] = 1;
          m_cnt[l] = 0;
          m_bad[l] = 0;
        end
      end
    end
  endtask

  task automatic compare();
    check("slip", {30'd0, SLIP}, {30'd0, m_slip[1], m_slip[0]});
    check("block_lock", {30'd0, BLOCK_LOCK}, {30'd0, m_lock[1], m_lock[0]});
    check("all_locked", {31'd0, ALL_LOCKED}, {31'd0, m_all});
    check("slip_count", {16'd0, SLIP_COUNT}, {16'd0, 8'(m_sc[1]), 8'(m_sc[0])});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    compare();
  endtask

  function automatic logic [1:0] vh();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] ih();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic send(input logic [1:0] v, input logic [1:0] h0, input logic [1:0] h1);
    hv  = v;
    hdr = {h1, h0};
    tick();
  endtask

  task automatic idle(input int n);
    hv = 2'b00;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Async reset asserted between clock edges; outputs must clear at once.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_async_zero", {15'd0, SLIP_COUNT, SLIP, BLOCK_LOCK, ALL_LOCKED}, 32'd0);
    compare();
    tick();
    rst = 1'b0;
  endtask

  task automatic pick(input int n);
    int k;
    int p;
    for (int i = 0; i < 64; i++) badpos[i] = 0;
    k = 0;
    while (k < n) begin
      p = $urandom_range(0, 63);
      if (!badpos[p]) begin
        badpos[p] = 1;
        k++;
      end
    end
  endtask

  initial begin
    int nbad;
    int sel;
    logic [1:0] h0;
    logic [1:0] h1;
    rst = 1'b1; en = 1'b0; hv = 2'b00; hdr = 4'h0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    en  = 1'b1;

    // 1: clean alternating headers on lane 0
    for (int i = 0; i < 64; i++) begin
      send(2'b01, (i % 2 == 1) ? 2'b10 : 2'b01, 2'b00);
      if (i == 62) check("t1_lock0_early", {31'd0, BLOCK_LOCK[0]}, 32'd0);
    end
    check("t1_lock0", {31'd0, BLOCK_LOCK[0]}, 32'd1);

    // 2: unlocked lane 1, 10th header invalid
    for (int i = 0; i < 10; i++) send(2'b10, 2'b00, (i == 9) ? ih() : vh());
    check("t2_slip1", {31'd0, SLIP[1]}, 32'd1);
    check("t2_cnt1", {24'd0, SLIP_COUNT[15:8]}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      send(2'b10, 2'b00, 2'($urandom_range(0, 3)));
      if (i == 0) check("t2_slip1_once", {31'd0, SLIP[1]}, 32'd0);
    end
    for (int i = 0; i < 64; i++) begin
      send(2'b10, 2'b00, vh());
      if (i == 62) check("t2_lock1_early", {31'd0, BLOCK_LOCK[1]}, 32'd0);
    end
    check("t2_lock1", {31'd0, BLOCK_LOCK[1]}, 32'd1);

    // 3: locked lane 0, 15 invalid holds lock, 16 invalid drops it
    pick(15);
    for (int i = 0; i < 64; i++) send(2'b01, badpos[i] ? ih() : vh(), 2'b00);
    check("t3_lock_held", {31'd0, BLOCK_LOCK[0]}, 32'd1);
    pick(16);
    nbad = 0;
    for (int i = 0; i < 64 && nbad < 16; i++) begin
      if (badpos[i]) nbad++;
      send(2'b01, badpos[i] ? ih() : vh(), 2'b00);
    end
    check("t3_slip0", {31'd0, SLIP[0]}, 32'd1);
    check("t3_unlock0", {31'd0, BLOCK_LOCK[0]}, 32'd0);
    idle(32);
    for (int i = 0; i < 64; i++) send(2'b01, vh(), 2'b00);
    check("t3_relock0", {31'd0, BLOCK_LOCK[0]}, 32'd1);

    // 4: last 16 headers of the window invalid
    for (int i = 0; i < 64; i++) send(2'b01, (i >= 48) ? ih() : vh(), 2'b00);
    check("t4_slip0", {31'd0, SLIP[0]}, 32'd1);
    check("t4_unlock0", {31'd0, BLOCK_LOCK[0]}, 32'd0);
    check("t4_cnt0", {24'd0, SLIP_COUNT[7:0]}, 32'd2);
    idle(32);

    // 5: reset mid-window, then enable drop while locked
    for (int i = 0; i < 10; i++) send(2'b11, vh(), vh());
    async_reset();
    send(2'b10, 2'b00, ih());
    idle(32);
    for (int i = 0; i < 64; i++) send(2'b11, vh(), vh());
    idle(1);
    check("t5_all_locked", {31'd0, ALL_LOCKED}, 32'd1);
    en = 1'b0;
    idle(1);
    check("t5_en_unlock", {30'd0, BLOCK_LOCK}, 32'd0);
    check("t5_cnt_kept", {24'd0, SLIP_COUNT[15:8]}, 32'd1);
    en = 1'b1;
    for (int i = 0; i < 64; i++) send(2'b11, vh(), vh());
    check("t5_relock", {30'd0, BLOCK_LOCK}, 32'd3);

    // 6: lane 0 clean, lane 1 slips three times before aligning
    async_reset();
    for (int k = 0; k < 3; k++) begin
      send(2'b11, vh(), ih());
      for (int i = 0; i < 32; i++) send(2'b11, vh(), vh());
    end
    for (int i = 0; i < 64; i++) send(2'b11, vh(), vh());
    check("t6_both_lock", {30'd0, BLOCK_LOCK}, 32'd3);
    check("t6_all_lag", {31'd0, ALL_LOCKED}, 32'd0);
    idle(1);
    check("t6_all_locked", {31'd0, ALL_LOCKED}, 32'd1);
    check("t6_cnt1", {24'd0, SLIP_COUNT[15:8]}, 32'd3);
    check("t6_cnt0", {24'd0, SLIP_COUNT[7:0]}, 32'd0);

    // Randomized segments with varying invalid-header density
    for (int seg = 0; seg < 15; seg++) begin
      sel = $urandom_range(0, 2);
      for (int c = 0; c < 200; c++) begin
        en = ($urandom_range(0, 199) != 0);
        h0 = vh();
        h1 = vh();
        if (sel == 1) begin
          if ($urandom_range(0, 39) == 0) h0 = ih();
          if ($urandom_range(0, 39) == 0) h1 = ih();
        end else if (sel == 2) begin
          if ($urandom_range(0, 2) == 0) h0 = ih();
          if ($urandom_range(0, 2) == 0) h1 = ih();
        end
        send(2'($urandom_range(0, 3)), h0, h1);
      end
    end
    en = 1'b1;

    // Slip counter saturation on lane 1
    async_reset();
    for (int k = 0; k < 260; k++) begin
      send(2'b10, 2'b00, ih());
      if (k == 259) check("sat_slip_still", {31'd0, SLIP[1]}, 32'd1);
      idle(32);
    end
    check("sat_cnt1", {24'd0, SLIP_COUNT[15:8]}, 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
